lfsr_modulator: RTL and testbench

//  Downstream consumer of the 5-bit LFSR pseudo-random bit stream (LFSR q[0], slow-clock domain).

---
 rtl/lfsr_modulator.sv | 158 +++++++++++++++
 tb/tb_lfsr_modulator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_modulator.sv
// Purpose: turns the slow-domain LFSR bit into a modulated DDS sample stream (ASK/FSK/BPSK/SQUARE).
// Latency: out_sample/out_valid/phase_inc_out register one clk after an accepted sample_en;
//          lfsr_bit reaches bit_edge/bit_count SYNC_STAGES+1 clk after it changes.
// Backpressure: none; every accepted strobe yields one out_valid pulse, back-to-back strobes included.
module lfsr_modulator #(
  parameter int DATA_W      = 12,
  parameter int PHASE_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      lfsr_bit,
  input  logic                      sample_en,
  input  logic [1:0]                mod_sel,
  input  logic signed [DATA_W-1:0]  sin_in,
  input  logic [PHASE_W-1:0]        phase_inc_f0,
  input  logic [PHASE_W-1:0]        phase_inc_f1,
  output logic signed [DATA_W-1:0]  out_sample,
  output logic                      out_valid,
  output logic [PHASE_W-1:0]        phase_inc_out,
  output logic                      bit_edge,
  output logic [15:0]               bit_count
);

  localparam logic [1:0] MODE_ASK    = 2'b00;
  localparam logic [1:0] MODE_FSK    = 2'b01;
  localparam logic [1:0] MODE_BPSK   = 2'b10;
  localparam logic [1:0] MODE_SQUARE = 2'b11;

  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MUTE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      bit_s;
  logic                      bit_s_d;
  logic                      armed;
  logic                      strobe;
  state_t                    state_q;
  state_t                    state_d;
  logic [1:0]                mode_q;
  logic                      mute_now;
  logic                      mode_load;
  logic                      phase_load;
  logic                      use_bit;
  logic signed [DATA_W-1:0]  neg_sin;
  logic signed [DATA_W-1:0]  sample_d;

  // Synchroniser chain bringing the slow-domain LFSR bit into clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lfsr_bit};
    end
  end

  assign bit_s = sync_q[SYNC_STAGES-1];

  // Edge detector and wrapping transition counter on the synchronised bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_s_d   <= 1'b0;
      bit_edge  <= 1'b0;
      bit_count <= 16'd0;
    end else begin
      bit_s_d  <= bit_s;
      bit_edge <= bit_s ^ bit_s_d;
      if (bit_s ^ bit_s_d) begin
        bit_count <= bit_count + 16'd1;
      end
    end
  end

  // Ignore a strobe arriving on the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  assign strobe = sample_en & armed;

  // The bit applied at a strobe is the settled (pre-edge) value; a change
  // seen in the same cycle only takes effect at the following strobe.
  assign use_bit = bit_s_d;

  // FSM state register and held mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ASK;
    end else begin
      state_q <= state_d;
      if (mode_load) begin
        mode_q <= mod_sel;
      end
    end
  end

  // Next-state logic; the FSM only moves on accepted strobes.
  always_comb begin
    state_d = state_q;
    if (strobe) begin
      unique case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  state_d = (mod_sel != mode_q) ? ST_MUTE : ST_RUN;
        ST_MUTE: state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode: pick the modulated sample and which registers load.
  always_comb begin
    mute_now   = (state_q == ST_RUN) && (mod_sel != mode_q);
    mode_load  = strobe && !mute_now;
    phase_load = strobe && !mute_now && (mod_sel == MODE_FSK);
    neg_sin    = (sin_in == S_MIN) ? S_MAX : -sin_in;
    sample_d   = '0;
    unique case (mod_sel)
      MODE_ASK:    sample_d = use_bit ? sin_in : '0;
      MODE_FSK:    sample_d = sin_in;
      MODE_BPSK:   sample_d = use_bit ? sin_in : neg_sin;
      MODE_SQUARE: sample_d = use_bit ? S_MAX : S_MIN;
      default:     sample_d = '0;
    endcase
    // A mode switch in RUN emits exactly one zero sample before the new mode.
    if (mute_now) begin
      sample_d = '0;
    end
  end

  // Registered outputs: sample, valid pulse and FSK phase increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_sample    <= '0;
      out_valid     <= 1'b0;
      phase_inc_out <= '0;
    end else begin
      out_valid <= strobe;
      if (strobe) begin
        out_sample <= sample_d;
      end
      if (phase_load) begin
        phase_inc_out <= use_bit ? phase_inc_f1 : phase_inc_f0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_modulator.sv
// Purpose: directed checks of lfsr_modulator with hand-computed expected values.
// Latency: samples outputs on the falling edge, one half-cycle after each active edge.
// Backpressure: n/a; all waits are fixed cycle counts so the run always terminates.
module tb_lfsr_modulator;

  logic               clk;
  logic               reset;
  logic               lfsr_bit;
  logic               sample_en;
  logic [1:0]         mod_sel;
  logic signed [11:0] sin_in;
  logic [31:0]        phase_inc_f0;
  logic [31:0]        phase_inc_f1;
  logic signed [11:0] out_sample;
  logic               out_valid;
  logic [31:0]        phase_inc_out;
  logic               bit_edge;
  logic [15:0]        bit_count;

  int n_vec;
  int n_err;
  int exp_cnt;

  lfsr_modulator #(
    .DATA_W      (12),
    .PHASE_W     (32),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lfsr_bit      (lfsr_bit),
    .sample_en     (sample_en),
    .mod_sel       (mod_sel),
    .sin_in        (sin_in),
    .phase_inc_f0  (phase_inc_f0),
    .phase_inc_f1  (phase_inc_f1),
    .out_sample    (out_sample),
    .out_valid     (out_valid),
    .phase_inc_out (phase_inc_out),
    .bit_edge      (bit_edge),
    .bit_count     (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [39:0] got,
                           input logic signed [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One strobe; outputs are checked on the falling edge after the capturing edge.
  task automatic strobe(input logic [1:0] ms, input logic signed [11:0] s,
                        input string tag, input logic signed [39:0] exp);
    @(negedge clk);
    mod_sel   = ms;
    sin_in    = s;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    check_val({tag, "_vld"}, out_valid, 1);
    check_val(tag, out_sample, exp);
  endtask

  // Drive the LFSR bit and watch where the edge pulse lands.
  task automatic set_bit(input logic b);
    int   pulses;
    int   pos;
    logic changed;
    pulses = 0;
    pos    = 0;
    @(negedge clk);
    changed  = (b !== lfsr_bit);
    if (changed) exp_cnt++;
    lfsr_bit = b;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bit_edge) begin
        pulses++;
        pos = i;
      end
    end
    check_val("edge_pulses", pulses, changed ? 1 : 0);
    if (changed) check_val("edge_delay", pos, 3);
    check_val("bit_count", bit_count, exp_cnt & 16'hFFFF);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    exp_cnt      = 0;
    reset        = 1'b0;
    lfsr_bit     = 1'b0;
    sample_en    = 1'b0;
    mod_sel      = 2'b00;
    sin_in       = '0;
    phase_inc_f0 = 32'h100;
    phase_inc_f1 = 32'h200;

    // Reset held with inputs toggling: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample_en = ~sample_en;
      lfsr_bit  = ~lfsr_bit;
      mod_sel   = mod_sel + 2'd1;
      sin_in    = 12'(i * 333 + 17);
      #1;
      check_val("rst_vld",   out_valid, 0);
      check_val("rst_smp",   out_sample, 0);
      check_val("rst_phase", phase_inc_out, 0);
      check_val("rst_edge",  bit_edge, 0);
      check_val("rst_cnt",   bit_count, 0);
    end
    @(negedge clk);
    sample_en = 1'b0;
    lfsr_bit  = 1'b0;
    mod_sel   = 2'b00;
    sin_in    = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);

    // ASK: bit 1 passes the sine, bit 0 gives zero.
    set_bit(1'b1);
    strobe(2'b00, 12'sd1000, "ask_b1", 1000);
    @(negedge clk);
    check_val("vld_one_cycle", out_valid, 0);
    set_bit(1'b0);
    strobe(2'b00, 12'sd1000, "ask_b0", 0);

    // BPSK with bit 0: first strobe is the mode-switch zero, then negation.
    strobe(2'b10, -12'sd2048, "bpsk_mute", 0);
    strobe(2'b10, -12'sd2048, "bpsk_sat", 2047);
    strobe(2'b10, 12'sd500, "bpsk_neg", -500);

    // Back-to-back strobes each produce a sample.
    @(negedge clk);
    sample_en = 1'b1;
    sin_in    = 12'sd100;
    @(negedge clk);
    sin_in    = 12'sd200;
    check_val("b2b_vld0", out_valid, 1);
    check_val("b2b_smp0", out_sample, -100);
    @(negedge clk);
    sample_en = 1'b0;
    check_val("b2b_vld1", out_valid, 1);
    check_val("b2b_smp1", out_sample, -200);

    // FSK: increment follows the bit only at strobes.
    strobe(2'b01, 12'sd300, "fsk_mute", 0);
    check_val("phase_pre_fsk", phase_inc_out, 0);
    strobe(2'b01, 12'sd300, "fsk_b0", 300);
    check_val("phase_f0", phase_inc_out, 32'h100);
    set_bit(1'b1);
    check_val("phase_hold_f0", phase_inc_out, 32'h100);
    strobe(2'b01, -12'sd300, "fsk_b1", -300);
    check_val("phase_f1", phase_inc_out, 32'h200);
    set_bit(1'b0);
    check_val("phase_hold_f1", phase_inc_out, 32'h200);
    strobe(2'b01, 12'sd42, "fsk_b0b", 42);
    check_val("phase_f0b", phase_inc_out, 32'h100);

    // Mode switches through ASK to SQUARE: one zero sample each time.
    set_bit(1'b1);
    strobe(2'b00, 12'sd700, "ask_mute", 0);
    strobe(2'b00, 12'sd700, "ask_run", 700);
    check_val("phase_hold_ask", phase_inc_out, 32'h100);
    strobe(2'b11, 12'sd5, "sq_mute", 0);
    strobe(2'b11, 12'sd5, "sq_b1", 2047);
    set_bit(1'b0);
    strobe(2'b11, 12'sd5, "sq_b0", -2048);

    // Asynchronous reset mid-stream clears at once.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("mid_rst_smp",   out_sample, 0);
    check_val("mid_rst_vld",   out_valid, 0);
    check_val("mid_rst_phase", phase_inc_out, 0);
    check_val("mid_rst_cnt",   bit_count, 0);
    exp_cnt   = 0;
    sample_en = 1'b1;
    mod_sel   = 2'b10;
    sin_in    = 12'sd500;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    check_val("release_strobe_ignored", out_valid, 0);
    // First strobe after release computes directly (no mute from reset mode ASK).
    strobe(2'b10, 12'sd500, "post_rst_bpsk", -500);

    // Counter wrap: 65535 toggles, then one more returns to zero.
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      lfsr_bit = ~lfsr_bit;
    end
    repeat (4) @(negedge clk);
    check_val("cnt_ffff", bit_count, 16'hFFFF);
    @(negedge clk);
    lfsr_bit = ~lfsr_bit;
    repeat (4) @(negedge clk);
    check_val("cnt_wrap", bit_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
